// File: rtl/weight_stream_loader.sv
// Coefficient stream consumer: fills a ping-pong pair of kernel-set banks from an FWFT stream
// and serves the completed bank through a ROM-style read port with one cycle of latency.
module weight_stream_loader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned KERN_S = 288,
    parameter int unsigned ADDR_W = $clog2(KERN_S)
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [DATA_W-1:0] input_V_dout,
    input  logic              input_V_empty_n,
    output logic              input_V_read,
    output logic              bank_ready,
    input  logic              bank_release,
    input  logic [ADDR_W-1:0] weight_address,
    input  logic              weight_ce,
    output logic [DATA_W-1:0] weight_q
);

    localparam int unsigned IdxW = $clog2(KERN_S);

    typedef enum logic [0:0] {
        StFill,
        StWait
    } state_e;

    state_e            state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [IdxW-1:0]   wr_addr_q, wr_addr_d;
    logic [1:0]        valid_q, valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] mem_q [2][KERN_S];

    logic            pop;
    logic            last_pop;
    logic            release_fire;
    logic            next_bank_free;
    logic            rd_oob;
    logic [IdxW-1:0] rd_idx;

    always_comb begin
        release_fire   = bank_release && valid_q[rd_bank_q];
        pop            = (state_q == StFill) && input_V_empty_n && !ap_rst;
        last_pop       = pop && (wr_addr_q == IdxW'(KERN_S - 1));
        // The bank we are about to switch to counts as free if it is being released right now.
        next_bank_free = !valid_q[~wr_bank_q] || (release_fire && (rd_bank_q != wr_bank_q));
        rd_idx         = weight_address[IdxW-1:0];
        rd_oob         = {1'b0, weight_address} >= (ADDR_W + 1)'(KERN_S);
        input_V_read   = pop;
        bank_ready     = valid_q[rd_bank_q];
        weight_q       = rdata_q;
    end

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_addr_d = wr_addr_q;
        valid_d   = valid_q;
        rdata_d   = rdata_q;

        if (release_fire) begin
            valid_d[rd_bank_q] = 1'b0;
            rd_bank_d          = ~rd_bank_q;
        end

        case (state_q)
            StFill: begin
                if (last_pop) begin
                    valid_d[wr_bank_q] = 1'b1;
                    wr_bank_d          = ~wr_bank_q;
                    wr_addr_d          = '0;
                    state_d            = next_bank_free ? StFill : StWait;
                end else if (pop) begin
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end
            StWait: begin
                if (!valid_q[wr_bank_q] || (release_fire && (rd_bank_q == wr_bank_q))) begin
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase

        if (weight_ce) begin
            rdata_d = rd_oob ? '0 : mem_q[rd_bank_q][rd_idx];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= StFill;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_addr_q <= '0;
            valid_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_addr_q <= wr_addr_d;
            valid_q   <= valid_d;
            rdata_q   <= rdata_d;
        end
    end

    // Bank storage is deliberately left out of reset.
    always_ff @(posedge ap_clk) begin
        if (pop) begin
            mem_q[wr_bank_q][wr_addr_q] <= input_V_dout;
        end
    end

endmodule
